// File: rtl/mem_line_splitter_16b.sv
// mem_line_splitter_16b
// Splits 16B cache line requests into four 4B word requests and gathers the
// word responses back into a single 16B response. Sub-word requests (len 1..4)
// pass through as one beat.
//
// Message packing (MSB first):
//   16B request  [174:0] = {type_[2:0], opaque[7:0], addr[31:0], len[3:0], data[127:0]}
//   16B response [144:0] = {type_[2:0], opaque[7:0], test[1:0], len[3:0], data[127:0]}
//   4B  request  [76:0]  = {type_[2:0], opaque[7:0], addr[31:0], len[1:0], data[31:0]}
//   4B  response [46:0]  = {type_[2:0], opaque[7:0], test[1:0], len[1:0], data[31:0]}
//
// Configuration macro: MEM_LINE_SPLITTER_PIPELINED_EN
//   defined   : up to four word requests outstanding
//   undefined : one word request outstanding at a time

module mem_line_splitter_16b (
    input  logic         clk,
    input  logic         reset,

    input  logic [174:0] line_reqstream_msg,
    input  logic         line_reqstream_val,
    output logic         line_reqstream_rdy,

    output logic [144:0] line_respstream_msg,
    output logic         line_respstream_val,
    input  logic         line_respstream_rdy,

    output logic [76:0]  word_reqstream_msg,
    output logic         word_reqstream_val,
    input  logic         word_reqstream_rdy,

    input  logic [46:0]  word_respstream_msg,
    input  logic         word_respstream_val,
    output logic         word_respstream_rdy
);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_ISSUE = 2'd1,
        ST_DRAIN = 2'd2,
        ST_RESP  = 2'd3
    } state_t;

    state_t         state_q,  state_d;
    logic [2:0]     icnt_q,   icnt_d;
    logic [2:0]     rcnt_q,   rcnt_d;
    logic [2:0]     nbeats_q, nbeats_d;
    logic [2:0]     type_q,   type_d;
    logic [7:0]     opaque_q, opaque_d;
    logic [31:0]    addr_q,   addr_d;
    logic [1:0]     wlen_q,   wlen_d;
    logic [127:0]   data_q,   data_d;
    logic [127:0]   gather_q, gather_d;
    logic [1:0]     test_q,   test_d;
    logic           issued_q, issued_d;

    logic           issue_ok_s;
    logic           line_req_fire_s;
    logic           line_resp_fire_s;
    logic           word_req_fire_s;
    logic           word_resp_fire_s;
    logic [3:0]     line_len_s;
    logic [1:0]     beat_s;
    logic [3:0]     resp_len_s;
    logic           unused_resp_bits_s;

    // Response type/opaque/len come back from memory but the latched request copy is authoritative.
    assign unused_resp_bits_s = ^{word_respstream_msg[46:36], word_respstream_msg[33:32], issued_q};

    assign line_len_s = line_reqstream_msg[131:128];
    assign beat_s     = icnt_q[1:0];

    // Outstanding-request gate for the word request port.
    always_comb begin
        issue_ok_s = 1'b0;
`ifdef MEM_LINE_SPLITTER_PIPELINED_EN
        issue_ok_s = (icnt_q < nbeats_q);
`else
        // Only issue once every earlier beat has been answered, and never back-to-back.
        issue_ok_s = (icnt_q < nbeats_q) && (icnt_q == rcnt_q) && !issued_q;
`endif
    end

    // Handshake outputs decoded from state only, forced low during reset.
    always_comb begin
        line_reqstream_rdy  = 1'b0;
        word_reqstream_val  = 1'b0;
        word_respstream_rdy = 1'b0;
        line_respstream_val = 1'b0;
        if (reset) begin
            line_reqstream_rdy  = 1'b0;
            word_reqstream_val  = 1'b0;
            word_respstream_rdy = 1'b0;
            line_respstream_val = 1'b0;
        end else begin
            line_reqstream_rdy  = (state_q == ST_IDLE);
            word_reqstream_val  = (state_q == ST_ISSUE) && issue_ok_s;
            word_respstream_rdy = (state_q == ST_ISSUE) || (state_q == ST_DRAIN);
            line_respstream_val = (state_q == ST_RESP);
        end
        line_req_fire_s  = line_reqstream_val  && line_reqstream_rdy;
        line_resp_fire_s = line_respstream_val && line_respstream_rdy;
        word_req_fire_s  = word_reqstream_val  && word_reqstream_rdy;
        word_resp_fire_s = word_respstream_val && word_respstream_rdy;
    end

    // Word request message: beat k of a line, or the single pass-through beat.
    always_comb begin
        word_reqstream_msg = 77'd0;
        if (nbeats_q == 3'd4) begin
            word_reqstream_msg = {type_q, {6'd0, beat_s}, {addr_q[31:4], beat_s, 2'b00},
                                  2'd0, data_q[{beat_s, 5'd0} +: 32]};
        end else begin
            word_reqstream_msg = {type_q, 8'd0, addr_q, wlen_q, data_q[31:0]};
        end
    end

    // Gathered line response message.
    always_comb begin
        resp_len_s          = 4'd0;
        line_respstream_msg = 145'd0;
        if (nbeats_q == 3'd4) begin
            resp_len_s          = 4'd0;
            line_respstream_msg = {type_q, opaque_q, test_q, resp_len_s, gather_q};
        end else begin
            if (wlen_q == 2'd0) begin
                resp_len_s = 4'd4;
            end else begin
                resp_len_s = {2'd0, wlen_q};
            end
            line_respstream_msg = {type_q, opaque_q, test_q, resp_len_s, {96'd0, gather_q[31:0]}};
        end
    end

    // Next-state logic: latch on accept, count beats, gather responses.
    always_comb begin
        state_d  = state_q;
        icnt_d   = icnt_q;
        rcnt_d   = rcnt_q;
        nbeats_d = nbeats_q;
        type_d   = type_q;
        opaque_d = opaque_q;
        addr_d   = addr_q;
        wlen_d   = wlen_q;
        data_d   = data_q;
        gather_d = gather_q;
        test_d   = test_q;
        issued_d = word_req_fire_s;

        if (word_req_fire_s) begin
            icnt_d = icnt_q + 3'd1;
        end else begin
            icnt_d = icnt_q;
        end

        if (word_resp_fire_s) begin
            gather_d[{rcnt_q[1:0], 5'd0} +: 32] = word_respstream_msg[31:0];
            rcnt_d = rcnt_q + 3'd1;
            test_d = word_respstream_msg[35:34];
        end else begin
            rcnt_d = rcnt_q;
        end

        case (state_q)
            ST_IDLE: begin
                if (line_req_fire_s) begin
                    type_d   = line_reqstream_msg[174:172];
                    opaque_d = line_reqstream_msg[171:164];
                    addr_d   = line_reqstream_msg[163:132];
                    data_d   = line_reqstream_msg[127:0];
                    if (line_len_s == 4'd0) begin
                        nbeats_d = 3'd4;
                        wlen_d   = 2'd0;
                    end else if (line_len_s <= 4'd4) begin
                        nbeats_d = 3'd1;
                        wlen_d   = line_len_s[1:0];
                    end else begin
                        // Illegal length: fall back to a full single word.
                        nbeats_d = 3'd1;
                        wlen_d   = 2'd0;
                    end
                    icnt_d   = 3'd0;
                    rcnt_d   = 3'd0;
                    gather_d = 128'd0;
                    test_d   = 2'd0;
                    state_d  = ST_ISSUE;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ISSUE: begin
                if (rcnt_d == nbeats_q) begin
                    state_d = ST_RESP;
                end else if (icnt_d == nbeats_q) begin
                    state_d = ST_DRAIN;
                end else begin
                    state_d = ST_ISSUE;
                end
            end
            ST_DRAIN: begin
                if (rcnt_d == nbeats_q) begin
                    state_d = ST_RESP;
                end else begin
                    state_d = ST_DRAIN;
                end
            end
            ST_RESP: begin
                if (line_resp_fire_s) begin
                    state_d = ST_IDLE;
                end else begin
                    state_d = ST_RESP;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    // State and datapath registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (reset) begin
            state_q  <= ST_IDLE;
            icnt_q   <= 3'd0;
            rcnt_q   <= 3'd0;
            nbeats_q <= 3'd0;
            type_q   <= 3'd0;
            opaque_q <= 8'd0;
            addr_q   <= 32'd0;
            wlen_q   <= 2'd0;
            data_q   <= 128'd0;
            gather_q <= 128'd0;
            test_q   <= 2'd0;
            issued_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            icnt_q   <= icnt_d;
            rcnt_q   <= rcnt_d;
            nbeats_q <= nbeats_d;
            type_q   <= type_d;
            opaque_q <= opaque_d;
            addr_q   <= addr_d;
            wlen_q   <= wlen_d;
            data_q   <= data_d;
            gather_q <= gather_d;
            test_q   <= test_d;
            issued_q <= issued_d;
        end
    end

`ifndef SYNTHESIS
    // Flag illegal request lengths in simulation.
    always @(posedge clk) begin
        if (!reset && line_req_fire_s && (line_len_s > 4'd4)) begin
            $error("mem_line_splitter_16b: illegal len %0d", line_len_s);
        end
    end

    function automatic string line_trace();
        return $sformatf("%s i%0d r%0d", state_q.name(), icnt_q, rcnt_q);
    endfunction
`endif

endmodule

// File: tb/tb_mem_line_splitter_16b.sv
// Directed bench for mem_line_splitter_16b against a zero-latency byte memory.

module tb_mem_line_splitter_16b;

    logic         clk = 1'b0;
    logic         reset;
    logic [174:0] line_reqstream_msg;
    logic         line_reqstream_val;
    logic         line_reqstream_rdy;
    logic [144:0] line_respstream_msg;
    logic         line_respstream_val;
    logic         line_respstream_rdy;
    logic [76:0]  word_reqstream_msg;
    logic         word_reqstream_val;
    logic         word_reqstream_rdy;
    logic [46:0]  word_respstream_msg;
    logic         word_respstream_val;
    logic         word_respstream_rdy;

    always #5 clk = ~clk;

    mem_line_splitter_16b dut (
        .clk                 (clk),
        .reset               (reset),
        .line_reqstream_msg  (line_reqstream_msg),
        .line_reqstream_val  (line_reqstream_val),
        .line_reqstream_rdy  (line_reqstream_rdy),
        .line_respstream_msg (line_respstream_msg),
        .line_respstream_val (line_respstream_val),
        .line_respstream_rdy (line_respstream_rdy),
        .word_reqstream_msg  (word_reqstream_msg),
        .word_reqstream_val  (word_reqstream_val),
        .word_reqstream_rdy  (word_reqstream_rdy),
        .word_respstream_msg (word_respstream_msg),
        .word_respstream_val (word_respstream_val),
        .word_respstream_rdy (word_respstream_rdy)
    );

    logic [7:0] mem     [0:65535];
    logic [7:0] ref_mem [0:65535];
    int cyc = 0;
    int n_cmp = 0;
    int n_bad = 0;

    logic [31:0] mon_addr [$];
    logic [31:0] mon_data [$];
    logic [1:0]  mon_len  [$];

    logic [2:0]  w_type;
    logic [7:0]  w_opq;
    logic [31:0] w_addr;
    logic [1:0]  w_len;
    logic [31:0] w_data;
    logic [31:0] w_rdata;

    assign w_type = word_reqstream_msg[76:74];
    assign w_opq  = word_reqstream_msg[73:66];
    assign w_addr = word_reqstream_msg[65:34];
    assign w_len  = word_reqstream_msg[33:32];
    assign w_data = word_reqstream_msg[31:0];

    // cycle counter
    always @(posedge clk) cyc <= cyc + 1;

    // zero-latency memory: the response fires in the same cycle as the request
    always_comb begin
        w_rdata = 32'd0;
        for (int i = 0; i < 4; i++) begin
            if ((w_len == 2'd0) || (i < int'(w_len))) begin
                w_rdata[8*i +: 8] = mem[w_addr[15:0] + 16'(i)];
            end
        end
        word_respstream_val = word_reqstream_val && word_reqstream_rdy;
        word_respstream_msg = {w_type, w_opq, w_opq[1:0] ^ 2'b01, w_len,
                               (w_type == 3'd0) ? w_rdata : 32'd0};
    end

    // memory writes and word-beat monitor
    always @(posedge clk) begin
        if (!reset && word_reqstream_val && word_reqstream_rdy) begin
            mon_addr.push_back(w_addr);
            mon_data.push_back(w_data);
            mon_len.push_back(w_len);
            if (w_type == 3'd1) begin
                for (int i = 0; i < 4; i++) begin
                    if ((w_len == 2'd0) || (i < int'(w_len))) begin
                        mem[w_addr[15:0] + 16'(i)] <= w_data[8*i +: 8];
                    end
                end
            end
        end
    end

    task automatic check_val(input string tag, input logic [144:0] act, input logic [144:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_bad++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
        end
    endtask

    task automatic preload_word(input logic [31:0] addr, input logic [31:0] w);
        for (int i = 0; i < 4; i++) begin
            mem[addr[15:0] + 16'(i)]     = w[8*i +: 8];
            ref_mem[addr[15:0] + 16'(i)] = w[8*i +: 8];
        end
    endtask

    task automatic mon_clear();
        mon_addr.delete();
        mon_data.delete();
        mon_len.delete();
    endtask

    // Send one line request and collect its response; lat = cycles from accept to resp val.
    task automatic run_txn(input logic [2:0] ty, input logic [31:0] addr, input logic [3:0] len,
                           input logic [127:0] data, input logic [7:0] opq, input bit rnd,
                           output logic [144:0] resp, output int lat);
        int  a_cyc;
        bit  ok;
        mon_clear();
        resp  = 145'd0;
        lat   = -1;
        a_cyc = 0;
        @(negedge clk);
        line_reqstream_msg = {ty, opq, addr, len, data};
        line_reqstream_val = 1'b1;
        ok = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (line_reqstream_rdy) begin
                ok    = 1'b1;
                a_cyc = cyc;
                break;
            end
            @(negedge clk);
        end
        if (!ok) check_val("accept_timeout", 145'd0, 145'd1);
        @(negedge clk);
        line_reqstream_val = 1'b0;
        line_reqstream_msg = 175'd0;
        ok = 1'b0;
        for (int k = 0; k < 400; k++) begin
            word_reqstream_rdy  = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            line_respstream_rdy = rnd ? 1'($urandom_range(0, 1)) : 1'b1;
            if (line_respstream_val && (lat < 0)) lat = cyc - a_cyc;
            if (line_respstream_val && line_respstream_rdy) begin
                resp = line_respstream_msg;
                ok   = 1'b1;
            end
            @(negedge clk);
            if (ok) break;
        end
        word_reqstream_rdy  = 1'b1;
        line_respstream_rdy = 1'b1;
        if (!ok) check_val("resp_timeout", 145'd0, 145'd1);
    endtask

    logic [144:0] resp;
    int           lat;
    int           exp_line_lat;
    logic [127:0] exp_data;
    logic [127:0] wdata;
    logic [31:0]  raddr;
    logic [2:0]   rty;
    int           bad_a;
    bit           ok2;

    initial begin
`ifdef MEM_LINE_SPLITTER_PIPELINED_EN
        exp_line_lat = 5;
`else
        exp_line_lat = 8;
`endif
        for (int i = 0; i < 65536; i++) begin
            mem[i]     = 8'd0;
            ref_mem[i] = 8'd0;
        end
        reset               = 1'b1;
        line_reqstream_msg  = 175'd0;
        line_reqstream_val  = 1'b0;
        line_respstream_rdy = 1'b1;
        word_reqstream_rdy  = 1'b1;

        // reset state
        repeat (3) @(negedge clk);
        check_val("reset_outputs",
                  145'({line_reqstream_rdy, word_reqstream_val, line_respstream_val, word_respstream_rdy}),
                  145'd0);
        reset = 1'b0;
        @(negedge clk);
        check_val("idle_outputs",
                  145'({line_reqstream_rdy, word_reqstream_val, line_respstream_val, word_respstream_rdy}),
                  145'b1000);

        // line read
        preload_word(32'h1000, 32'h11111111);
        preload_word(32'h1004, 32'h22222222);
        preload_word(32'h1008, 32'h33333333);
        preload_word(32'h100C, 32'h44444444);
        run_txn(3'd0, 32'h1000, 4'd0, 128'd0, 8'h5A, 1'b0, resp, lat);
        check_val("rd_line_resp", resp,
                  {3'd0, 8'h5A, 2'b10, 4'd0, 128'h44444444_33333333_22222222_11111111});
        check_val("rd_line_beats", 145'(mon_addr.size()), 145'd4);
        if (mon_addr.size() == 4)
            check_val("rd_line_addrs", 145'({mon_addr[0], mon_addr[1], mon_addr[2], mon_addr[3]}),
                      145'({32'h1000, 32'h1004, 32'h1008, 32'h100C}));
        check_val("rd_line_latency", 145'(lat), 145'(exp_line_lat));

        // line write
        run_txn(3'd1, 32'h2010, 4'd0, 128'hDDDDDDDD_CCCCCCCC_BBBBBBBB_AAAAAAAA, 8'h21, 1'b0, resp, lat);
        check_val("wr_line_resp", resp, {3'd1, 8'h21, 2'b10, 4'd0, 128'd0});
        check_val("wr_line_beats", 145'(mon_addr.size()), 145'd4);
        if (mon_addr.size() == 4) begin
            check_val("wr_line_addrs", 145'({mon_addr[0], mon_addr[1], mon_addr[2], mon_addr[3]}),
                      145'({32'h2010, 32'h2014, 32'h2018, 32'h201C}));
            check_val("wr_line_data", 145'({mon_data[0], mon_data[1], mon_data[2], mon_data[3]}),
                      145'({32'hAAAAAAAA, 32'hBBBBBBBB, 32'hCCCCCCCC, 32'hDDDDDDDD}));
        end
        check_val("wr_line_mem", 145'({mem[16'h201F], mem[16'h2010]}), 145'(16'hDDAA));

        // sub-word read
        preload_word(32'h3000, 32'hA5334455);
        preload_word(32'h3004, 32'h77777777);
        run_txn(3'd0, 32'h3003, 4'd1, 128'd0, 8'h33, 1'b0, resp, lat);
        check_val("subword_resp", resp, {3'd0, 8'h33, 2'b01, 4'd1, 128'h000000A5});
        check_val("subword_beats", 145'(mon_addr.size()), 145'd1);
        if (mon_addr.size() == 1)
            check_val("subword_req", 145'({mon_addr[0], mon_len[0]}), 145'({32'h3003, 2'd1}));
        check_val("subword_latency", 145'(lat), 145'd2);

        // single-word write (len 4)
        run_txn(3'd1, 32'h4000, 4'd4, 128'h12345678_9ABCDEF0_0BADBEEF_CAFEF00D, 8'h44, 1'b0, resp, lat);
        check_val("sword_resp", resp, {3'd1, 8'h44, 2'b01, 4'd4, 128'd0});
        check_val("sword_beats", 145'(mon_addr.size()), 145'd1);
        if (mon_addr.size() == 1)
            check_val("sword_req", 145'({mon_addr[0], mon_len[0], mon_data[0]}),
                      145'({32'h4000, 2'd0, 32'hCAFEF00D}));
        check_val("sword_mem", 145'({mem[16'h4003], mem[16'h4002], mem[16'h4001], mem[16'h4000]}),
                  145'(32'hCAFEF00D));

        // random back-pressure
        for (int t = 0; t < 200; t++) begin
            rty   = 3'($urandom_range(0, 1));
            raddr = 32'h8000 + {22'd0, 6'($urandom_range(0, 63)), 4'h0};
            wdata = {$urandom, $urandom, $urandom, $urandom};
            exp_data = 128'd0;
            if (rty == 3'd0) begin
                for (int i = 0; i < 16; i++) exp_data[8*i +: 8] = ref_mem[raddr[15:0] + 16'(i)];
            end else begin
                for (int i = 0; i < 16; i++) ref_mem[raddr[15:0] + 16'(i)] = wdata[8*i +: 8];
            end
            run_txn(rty, raddr, 4'd0, wdata, 8'(t), 1'b1, resp, lat);
            check_val("rnd_resp", resp, {rty, 8'(t), 2'b10, 4'd0, exp_data});
            bad_a = (mon_addr.size() == 4) ? 0 : 1;
            for (int i = 0; i < mon_addr.size(); i++)
                if (mon_addr[i] !== raddr + 32'(4 * i)) bad_a++;
            check_val("rnd_beats", 145'(bad_a), 145'd0);
        end

        // reset mid-operation after two beats
        mon_clear();
        word_reqstream_rdy  = 1'b1;
        line_respstream_rdy = 1'b1;
        @(negedge clk);
        line_reqstream_msg = {3'd0, 8'h77, 32'h1000, 4'd0, 128'd0};
        line_reqstream_val = 1'b1;
        ok2 = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (line_reqstream_rdy) begin
                ok2 = 1'b1;
                break;
            end
            @(negedge clk);
        end
        @(negedge clk);
        line_reqstream_val = 1'b0;
        line_reqstream_msg = 175'd0;
        ok2 = 1'b0;
        for (int k = 0; k < 50; k++) begin
            if (mon_addr.size() >= 2) begin
                ok2 = 1'b1;
                break;
            end
            @(negedge clk);
        end
        check_val("midrst_two_beats", 145'(ok2), 145'd1);
        reset = 1'b1;
        @(negedge clk);
        check_val("midrst_outputs",
                  145'({line_reqstream_rdy, word_reqstream_val, line_respstream_val, word_respstream_rdy}),
                  145'd0);
        check_val("midrst_no_more_beats", 145'(mon_addr.size()), 145'd2);
        reset = 1'b0;
        @(negedge clk);
        check_val("midrst_idle",
                  145'({line_reqstream_rdy, word_reqstream_val, line_respstream_val, word_respstream_rdy}),
                  145'b1000);
        run_txn(3'd0, 32'h1000, 4'd0, 128'd0, 8'h78, 1'b0, resp, lat);
        check_val("midrst_reread", resp,
                  {3'd0, 8'h78, 2'b10, 4'd0, 128'h44444444_33333333_22222222_11111111});

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

    // hard time limit
    initial begin
        #900000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/mem_line_splitter_16b.md
# mem_line_splitter_16b

Memory-side adapter between the 16B cache refill/evict port and a 4B-wide memory. Each 16B line request from the cache is split into four 4B word requests. Word responses are gathered and one 16B response is returned. Sub-word requests (len 1..4) pass through as a single beat. The block sits between `cache2mem_*` of the 16B cache and any 4B `mem_req_4B_t`/`mem_resp_4B_t` memory or test source/sink.

## Interface
- Parameters: none. All widths are fixed by `mem_req_16B_t`, `mem_resp_16B_t`, `mem_req_4B_t` and `mem_resp_4B_t` from `vc/mem-msgs.v`.
- `clk` in 1: the single clock.
- `reset` in 1: synchronous, active-high.
- `line_reqstream_msg` in `mem_req_16B_t`: request from the cache.
- `line_reqstream_val` in 1 / `line_reqstream_rdy` out 1.
- `line_respstream_msg` out `mem_resp_16B_t`: gathered response to the cache.
- `line_respstream_val` out 1 / `line_respstream_rdy` in 1.
- `word_reqstream_msg` out `mem_req_4B_t`: request to the 4B memory.
- `word_reqstream_val` out 1 / `word_reqstream_rdy` in 1.
- `word_respstream_msg` in `mem_resp_4B_t`: response from the 4B memory, returned in order.
- `word_respstream_val` in 1 / `word_respstream_rdy` out 1.

## Operation
- **States:** IDLE, ISSUE, DRAIN, RESP. Reset enters IDLE.
- **IDLE**
  - `line_reqstream_rdy`=1.
  - On fire, latch the message.
  - Compute `nbeats`: 4 if len==0, otherwise 1.
  - Clear the issue counter `icnt` and the response counter `rcnt`.
  - Go to ISSUE.
- **ISSUE**
  - `word_reqstream_val`=1 while `icnt`<`nbeats` and the outstanding limit is not reached.
  - Beat k of a line request:
    - addr = {addr[31:4], k[1:0], 2'b00}
    - len = 0
    - data = line data[32k+31:32k]
    - type_ = latched type_
    - opaque = {6'b0, k}
  - Single-beat request:
    - addr is unchanged.
    - len: 16B len 4 maps to 2'd0; len 1..3 maps to len[1:0].
    - data = data[31:0]; opaque = 0.
  - When `icnt` reaches `nbeats`, go to DRAIN.
- **ISSUE and DRAIN:** `word_reqstream_rdy`... the word response port:
  - `word_respstream_rdy`=1.
  - Each response fire writes its data into slot `rcnt` of a 128-bit gather register, then increments `rcnt`.
  - The last response's `test` field is latched.
  - When `rcnt` reaches `nbeats`, go to RESP.
- **RESP**
  - `line_respstream_val`=1.
  - msg.type_ = latched type_; msg.opaque = latched opaque; msg.test = latched test.
  - msg.len: 0 for a line; for a single beat, word len 0 maps to 4, otherwise {2'b0, len}.
  - msg.data: gather register for a line; {96'b0, word data} for a single beat.
  - On fire, go to IDLE.
- **Write responses:** the gather data is don't-care, but the bench checks data==0. Gather register lanes are cleared on request accept.
- **Illegal len:** len 5..15 is illegal. Simulation-only `$error`; the request is treated as a single beat with word len 0.
- **Line trace:** `line_trace` prints the state and `icnt`/`rcnt` under `ifndef SYNTHESIS`.

## Timing
- **Reset values:** all `val` and `rdy` outputs are 0 while `reset` is high. After reset: state IDLE, counters 0, gather register 0.
- **Handshake:** a fire occurs when val && rdy in the same cycle. `val` must not depend combinationally on the partner's `rdy`. A message stays stable while val=1 and rdy=0.
- **Request issue:** no request is issued in the accept cycle. Beat 0 is earliest in cycle A+1, where A is the accept cycle.
- **Pipelined mode:** one beat per cycle when `word_reqstream_rdy`=1.
  - With a zero-latency memory, the last response arrives at A+4 for a line and A+1 for a single beat.
  - `line_respstream_val` rises the cycle after the last response fire: A+5 for a line, A+2 for a single beat.
- **Simultaneous events:** a request fire and a response fire in the same cycle both take effect. `rcnt`==`nbeats` is evaluated after the update.
- **Back-pressure:**
  - `word_reqstream_rdy`=0 stalls `icnt`.
  - `line_respstream_rdy`=0 holds RESP indefinitely.
  - No new line request is accepted until the RESP fire; the next accept is earliest the cycle after it.
- **Reset mid-operation:** returns to IDLE immediately and drops latched state. The memory side must be reset in the same cycle; word responses arriving after reset are not consumed.

## Configuration
- **`MEM_LINE_SPLITTER_PIPELINED_EN` defined:** up to 4 word requests are outstanding. Issue is gated only by `icnt`<`nbeats`.
- **Not defined:**
  - At most one word request is outstanding: beat k+1 is issued only after response k fires.
  - With zero-latency memory, issue of beat k+1 waits for response k, so consecutive issues are at least 2 cycles apart.
  - Functional results are identical in both modes.

## Test plan
- **Line read:** addr 0x1000, len 0; memory words 0x11111111, 0x22222222, 0x33333333, 0x44444444 at 0x1000–0x100C.
  - Word addrs issued: 0x1000, 0x1004, 0x1008, 0x100C.
  - Response data 0x44444444_33333333_22222222_11111111, len 0, opaque echoed.
- **Line write:** addr 0x2010, data 0xDDDD..CCCC..BBBB..AAAA.
  - Four writes with word data 0xAAAAAAAA at 0x2010 through 0xDDDDDDDD at 0x201C.
  - One write response, len 0.
- **Sub-word read:** len 1, addr 0x3003 → one word request with len 1, addr 0x3003; response len 1, data in [7:0], upper bits 0.
- **Single-word write:** len 4 → one word request with len 0; response len 4.
- **Back-pressure:** random `word_reqstream_rdy` and `line_respstream_rdy` at 50%, 200 random line reads/writes against a reference memory → all data matches, no dropped or duplicated beats.
- **Reset mid-operation:** reset asserted mid-line after 2 beats, with the memory reset in the same cycle → all outputs 0 the next cycle. A new line read then completes correctly.
